// File: rtl/vx_nc_req_sched.sv
// Round-robin scheduler for non-cacheable requests onto a single registered memory request channel,
// with read credit limiting and a drain handshake. Define VX_NC_SCHED_PERF_EN to add perf counters.
module vx_nc_req_sched #(
  parameter int NUM_REQS    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_SIZE   = 4,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 4,
  localparam int TIDW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int CNTW = $clog2(MAX_PENDING + 1)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_REQS-1:0]                      req_valid,
  input  logic [NUM_REQS-1:0]                      req_rw,
  input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]      req_addr,
  input  logic [NUM_REQS-1:0][DATA_SIZE-1:0]       req_byteen,
  input  logic [NUM_REQS-1:0][DATA_SIZE*8-1:0]     req_data,
  input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]       req_tag,
  output logic [NUM_REQS-1:0]                      req_ready,
  output logic                                     mem_req_valid,
  output logic                                     mem_req_rw,
  output logic [ADDR_WIDTH-1:0]                    mem_req_addr,
  output logic [DATA_SIZE-1:0]                     mem_req_byteen,
  output logic [DATA_SIZE*8-1:0]                   mem_req_data,
  output logic [TIDW+TAG_WIDTH-1:0]                mem_req_tag,
  input  logic                                     mem_req_ready,
  input  logic                                     mem_rsp_valid,
  input  logic                                     mem_rsp_ready,
  input  logic                                     drain_req,
  output logic                                     drain_done,
  output logic [CNTW-1:0]                          pending_count
`ifdef VX_NC_SCHED_PERF_EN
  ,
  output logic [31:0]                              perf_reads,
  output logic [31:0]                              perf_writes,
  output logic [31:0]                              perf_stalls
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [TIDW-1:0]           rrPtr_q, rrPtr_d;
  logic [CNTW-1:0]           pending_q, pending_d;
  logic                      memValid_q, memValid_d;
  logic                      memRw_q, memRw_d;
  logic [ADDR_WIDTH-1:0]     memAddr_q, memAddr_d;
  logic [DATA_SIZE-1:0]      memByteen_q, memByteen_d;
  logic [DATA_SIZE*8-1:0]    memData_q, memData_d;
  logic [TIDW+TAG_WIDTH-1:0] memTag_q, memTag_d;

  logic [NUM_REQS-1:0] eligible;
  logic                canLoad;
  logic                grantFound;
  logic [TIDW-1:0]     grantIdx;
  logic                hiFound, loFound;
  logic [TIDW-1:0]     hiIdx, loIdx;
  logic                accept;
  logic                creditInc, creditDec;

  // Credit check uses only the registered count, so responses never reach req_ready combinationally.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = req_valid[i] && (req_rw[i] || (pending_q < CNTW'(MAX_PENDING)));
    end
  end

  // Cyclic priority scan: prefer the lowest eligible index at or above the pointer, else wrap to the lowest overall.
  always_comb begin
    hiFound = 1'b0;
    hiIdx   = '0;
    loFound = 1'b0;
    loIdx   = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        loFound = 1'b1;
        loIdx   = TIDW'(i);
        if (i >= int'(rrPtr_q)) begin
          hiFound = 1'b1;
          hiIdx   = TIDW'(i);
        end
      end
    end
    grantFound = loFound;
    grantIdx   = hiFound ? hiIdx : loIdx;
  end

  assign canLoad = (state_q == RUN) && (!memValid_q || mem_req_ready);
  assign accept  = reset && canLoad && grantFound;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grantIdx] = 1'b1;
    end
  end

  // Output buffer reloads directly on a downstream handshake, giving one request per cycle.
  always_comb begin
    memValid_d  = memValid_q;
    memRw_d     = memRw_q;
    memAddr_d   = memAddr_q;
    memByteen_d = memByteen_q;
    memData_d   = memData_q;
    memTag_d    = memTag_q;
    rrPtr_d     = rrPtr_q;
    if (accept) begin
      memValid_d  = 1'b1;
      memRw_d     = req_rw[grantIdx];
      memAddr_d   = req_addr[grantIdx];
      memByteen_d = req_byteen[grantIdx];
      memData_d   = req_data[grantIdx];
      memTag_d    = {grantIdx, req_tag[grantIdx]};
      rrPtr_d     = (grantIdx == TIDW'(NUM_REQS - 1)) ? '0 : grantIdx + TIDW'(1);
    end else if (mem_req_ready) begin
      memValid_d  = 1'b0;
    end
  end

  assign creditInc = accept && !req_rw[grantIdx];
  assign creditDec = mem_rsp_valid && mem_rsp_ready && (pending_q != '0);

  always_comb begin
    pending_d = pending_q;
    if (creditInc && !creditDec) begin
      pending_d = pending_q + CNTW'(1);
    end else if (!creditInc && creditDec) begin
      pending_d = pending_q - CNTW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (drain_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (!drain_req) begin
          state_d = RUN;
        end else if (!memValid_q && (pending_q == '0)) begin
          state_d = DRAINED;
        end
      end
      DRAINED: begin
        if (!drain_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      rrPtr_q     <= '0;
      pending_q   <= '0;
      memValid_q  <= 1'b0;
      memRw_q     <= 1'b0;
      memAddr_q   <= '0;
      memByteen_q <= '0;
      memData_q   <= '0;
      memTag_q    <= '0;
    end else begin
      state_q     <= state_d;
      rrPtr_q     <= rrPtr_d;
      pending_q   <= pending_d;
      memValid_q  <= memValid_d;
      memRw_q     <= memRw_d;
      memAddr_q   <= memAddr_d;
      memByteen_q <= memByteen_d;
      memData_q   <= memData_d;
      memTag_q    <= memTag_d;
    end
  end

  assign mem_req_valid  = memValid_q;
  assign mem_req_rw     = memRw_q;
  assign mem_req_addr   = memAddr_q;
  assign mem_req_byteen = memByteen_q;
  assign mem_req_data   = memData_q;
  assign mem_req_tag    = memTag_q;
  assign pending_count  = pending_q;
  assign drain_done     = (state_q == DRAINED);

`ifdef VX_NC_SCHED_PERF_EN
  logic [31:0] perfReads_q, perfWrites_q, perfStalls_q;

  // Stall cycles are those with any request present but nothing accepted, including drain periods.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perfReads_q  <= '0;
      perfWrites_q <= '0;
      perfStalls_q <= '0;
    end else begin
      if (accept && !req_rw[grantIdx]) perfReads_q  <= perfReads_q + 32'd1;
      if (accept && req_rw[grantIdx])  perfWrites_q <= perfWrites_q + 32'd1;
      if ((|req_valid) && !accept)     perfStalls_q <= perfStalls_q + 32'd1;
    end
  end

  assign perf_reads  = perfReads_q;
  assign perf_writes = perfWrites_q;
  assign perf_stalls = perfStalls_q;
`endif

endmodule

// File: tb/tb_vx_nc_req_sched.sv
// Scoreboard bench for vx_nc_req_sched: directed scenarios plus random traffic against a
// behavioural model of the grant, credit and drain rules.
module tb_vx_nc_req_sched;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DS   = 4;
  localparam int TW   = 8;
  localparam int MP   = 2;
  localparam int TIDW = 2;
  localparam int CNTW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       resetN;
  logic [N-1:0]               reqValid, reqRw, reqReady;
  logic [N-1:0][AW-1:0]       reqAddr;
  logic [N-1:0][DS-1:0]       reqByteen;
  logic [N-1:0][DS*8-1:0]     reqData;
  logic [N-1:0][TW-1:0]       reqTag;
  logic                       memReqValid, memReqRw, memReqReady;
  logic [AW-1:0]              memReqAddr;
  logic [DS-1:0]              memReqByteen;
  logic [DS*8-1:0]            memReqData;
  logic [TIDW+TW-1:0]         memReqTag;
  logic                       memRspValid, memRspReady, drainReq, drainDone;
  logic [CNTW-1:0]            pendingCount;

  vx_nc_req_sched #(
    .NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(TW), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .reset(resetN),
    .req_valid(reqValid), .req_rw(reqRw), .req_addr(reqAddr), .req_byteen(reqByteen),
    .req_data(reqData), .req_tag(reqTag), .req_ready(reqReady),
    .mem_req_valid(memReqValid), .mem_req_rw(memReqRw), .mem_req_addr(memReqAddr),
    .mem_req_byteen(memReqByteen), .mem_req_data(memReqData), .mem_req_tag(memReqTag),
    .mem_req_ready(memReqReady), .mem_rsp_valid(memRspValid), .mem_rsp_ready(memRspReady),
    .drain_req(drainReq), .drain_done(drainDone), .pending_count(pendingCount)
  );

  typedef struct packed {
    logic               rw;
    logic [AW-1:0]      addr;
    logic [DS-1:0]      byteen;
    logic [DS*8-1:0]    data;
    logic [TIDW+TW-1:0] tag;
  } memReqT;

  memReqT expQ[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: pointer, credit count, drain mode (0 run, 1 draining, 2 drained), buffer occupancy.
  int mPtr, mPend, mMode;
  bit mBufV;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    mPtr  = 0;
    mPend = 0;
    mMode = 0;
    mBufV = 0;
    expQ.delete();
  endtask

  task automatic clearInputs();
    reqValid    = '0;
    reqRw       = '0;
    memReqReady = 1'b1;
    memRspValid = 1'b0;
    memRspReady = 1'b0;
    drainReq    = 1'b0;
  endtask

  task automatic randomFields();
    for (int i = 0; i < N; i++) begin
      reqAddr[i]   = $urandom;
      reqByteen[i] = DS'($urandom);
      reqData[i]   = $urandom;
      reqTag[i]    = TW'($urandom);
    end
  endtask

  // One clock: inputs are already set by the caller; check at mid-low phase, advance the model, return after posedge.
  task automatic applyStimulus();
    int              g;
    logic [TIDW-1:0] ix;
    bit              canLoad, accept, fire;
    logic [N-1:0]    expReady;
    memReqT          e;
    int              p;
    @(negedge clk);
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      ix = TIDW'((mPtr + k) % N);
      if (g < 0 && reqValid[ix] && (reqRw[ix] || mPend < MP)) g = int'(ix);
    end
    canLoad  = (mMode == 0) && (!mBufV || memReqReady);
    accept   = canLoad && (g >= 0);
    expReady = '0;
    if (accept) expReady[TIDW'(g)] = 1'b1;
    checkOutput("req_ready", 128'(reqReady), 128'(expReady));
    checkOutput("mem_req_valid", 128'(memReqValid), 128'(mBufV));
    checkOutput("pending_count", 128'(pendingCount), 128'(mPend));
    checkOutput("drain_done", 128'(drainDone), 128'(mMode == 2));
    fire = memRspValid && memRspReady;
    p = mPend;
    if (accept) begin
      ix       = TIDW'(g);
      e.rw     = reqRw[ix];
      e.addr   = reqAddr[ix];
      e.byteen = reqByteen[ix];
      e.data   = reqData[ix];
      e.tag    = {ix, reqTag[ix]};
      expQ.push_back(e);
      if (!reqRw[ix]) p++;
      mPtr = (g + 1) % N;
    end
    if (fire && mPend > 0) p--;
    case (mMode)
      0: if (drainReq) mMode = 1;
      1: if (!drainReq) mMode = 0; else if (!mBufV && mPend == 0) mMode = 2;
      default: if (!drainReq) mMode = 0;
    endcase
    mBufV = accept ? 1'b1 : (memReqReady ? 1'b0 : mBufV);
    mPend = p;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; asserts reset between edges and checks the asynchronous clear.
  task automatic midReset();
    #3;
    resetN = 1'b0;
    #1;
    checkOutput("async_rst_mem_req_valid", 128'(memReqValid), 128'(0));
    checkOutput("async_rst_pending", 128'(pendingCount), 128'(0));
    checkOutput("async_rst_req_ready", 128'(reqReady), 128'(0));
    checkOutput("async_rst_drain_done", 128'(drainDone), 128'(0));
    modelReset();
    clearInputs();
    @(negedge clk);
    @(posedge clk);
    #3;
    resetN = 1'b1;
  endtask

  // Scoreboard monitor: every downstream handshake pops the oldest expected request.
  initial begin
    memReqT e;
    forever begin
      @(negedge clk);
      #2;
      if (resetN && memReqValid && memReqReady) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL scoreboard_empty actual=%0h expected=none", memReqTag);
        end else begin
          e = expQ.pop_front();
          checkOutput("mem_req_tag", 128'(memReqTag), 128'(e.tag));
          checkOutput("mem_req_fields", 128'({memReqRw, memReqAddr, memReqByteen, memReqData}),
                      128'({e.rw, e.addr, e.byteen, e.data}));
        end
      end
    end
  end

  initial begin
    resetN = 1'b0;
    clearInputs();
    randomFields();
    modelReset();
    reqValid = 4'hF;
    reqRw    = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_mem_req_valid", 128'(memReqValid), 128'(0));
    checkOutput("reset_pending", 128'(pendingCount), 128'(0));
    checkOutput("reset_drain_done", 128'(drainDone), 128'(0));
    checkOutput("reset_req_ready", 128'(reqReady), 128'(0));
    #2;
    resetN = 1'b1;

    $display("[TB] round-robin writes");
    repeat (6) begin
      randomFields();
      applyStimulus();
    end

    $display("[TB] read credit limit");
    clearInputs();
    reqValid = 4'b0001;
    repeat (4) begin
      randomFields();
      applyStimulus();
    end
    memRspValid = 1'b1;
    memRspReady = 1'b1;
    applyStimulus();
    memRspValid = 1'b0;
    repeat (2) applyStimulus();

    $display("[TB] write bypasses exhausted credits");
    reqValid = 4'b0110;
    reqRw    = 4'b0010;
    repeat (3) begin
      randomFields();
      applyStimulus();
    end
    clearInputs();
    memRspValid = 1'b1;
    memRspReady = 1'b1;
    repeat (3) applyStimulus();

    $display("[TB] downstream backpressure");
    clearInputs();
    reqValid    = 4'b1000;
    reqRw       = 4'b1000;
    memReqReady = 1'b0;
    randomFields();
    repeat (6) applyStimulus();
    memReqReady = 1'b1;
    repeat (2) begin
      randomFields();
      applyStimulus();
    end

    $display("[TB] drain sequence");
    clearInputs();
    reqValid = 4'b0001;
    applyStimulus();
    reqValid = '0;
    applyStimulus();
    drainReq = 1'b1;
    reqValid = 4'hF;
    reqRw    = 4'hF;
    repeat (4) applyStimulus();
    memRspValid = 1'b1;
    memRspReady = 1'b1;
    applyStimulus();
    memRspValid = 1'b0;
    repeat (2) applyStimulus();
    drainReq = 1'b0;
    repeat (3) begin
      randomFields();
      applyStimulus();
    end

    $display("[TB] read accept with response in same cycle");
    clearInputs();
    memRspValid = 1'b1;
    memRspReady = 1'b1;
    repeat (3) applyStimulus();
    memRspValid = 1'b0;
    reqValid = 4'b0100;
    applyStimulus();
    memRspValid = 1'b1;
    reqValid    = 4'b0010;
    applyStimulus();
    clearInputs();
    applyStimulus();

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      reqValid    = N'($urandom);
      reqRw       = N'($urandom);
      memReqReady = ($urandom % 4) != 0;
      memRspValid = ($urandom % 2) != 0;
      memRspReady = ($urandom % 4) != 0;
      if ($urandom % 30 == 0) drainReq = ~drainReq;
      randomFields();
      if (c == 300) midReset();
      else applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
